// File: rtl/motion_cmd_sequencer.sv
// motion_cmd_sequencer
//   Queues plotter motion commands from the G-code decoder and hands them to
//   the motors controller one at a time over a trigger / rdy / done handshake.
//
//   Handshakes:
//     producer side : a command is accepted on any clk edge where
//                     cmd_valid && cmd_rdy. cmd_rdy is registered from the
//                     next-cycle full flag; it never depends on cmd_valid.
//     motor side    : mot_trigger is a one-clk pulse with mot_* stable from
//                     the cycle before it. mot_rdy is sampled before launch.
//                     mot_done is a one-clk pulse, honoured only in WAIT.
//
//   Optional feature macro: MOTION_SEQ_AUTO_LIFT_EN
//     When defined, an empty queue with the pen down for IDLE_TICKS clk_en
//     ticks launches an internal pen-up command (zero pulses).
//     When undefined, the pen state changes only by queued commands.
module motion_cmd_sequencer #(
    parameter int PULSE_X_BITS = 16,
    parameter int PULSE_Y_BITS = 16,
    parameter int DEPTH        = 8,
    parameter int IDLE_TICKS   = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      cmd_valid,
    output logic                      cmd_rdy,
    input  logic [PULSE_X_BITS-1:0]   cmd_pulse_x,
    input  logic                      cmd_dir_x,
    input  logic [PULSE_Y_BITS-1:0]   cmd_pulse_y,
    input  logic                      cmd_dir_y,
    input  logic                      cmd_pen_down,
    output logic                      mot_trigger,
    input  logic                      mot_rdy,
    input  logic                      mot_done,
    output logic [PULSE_X_BITS-1:0]   mot_pulse_x,
    output logic                      mot_dir_x,
    output logic [PULSE_Y_BITS-1:0]   mot_pulse_y,
    output logic                      mot_dir_y,
    output logic                      mot_pen_down,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      busy,
    output logic [1:0]                fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = PULSE_X_BITS + PULSE_Y_BITS + 3;
    // Packed entry layout: {pulse_x, dir_x, pulse_y, dir_y, pen_down}
    localparam int PY_LO = 2;
    localparam int DX_B  = PULSE_Y_BITS + 2;
    localparam int PX_LO = PULSE_Y_BITS + 3;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("motion_cmd_sequencer: DEPTH must be a power of two >= 2");
    end
    if (IDLE_TICKS < 1) begin : g_bad_ticks
        $error("motion_cmd_sequencer: IDLE_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_nxt;
    logic [CW-1:0]   mem [DEPTH];
    logic [CW-1:0]   head;
    logic            push;
    logic            pop;
    logic            done_pend;

    assign push      = cmd_valid && cmd_rdy;
    assign pop       = (state == ST_IDLE) && clk_en && (level != '0) && mot_rdy;
    assign head      = mem[rd_ptr];
    assign busy      = (state != ST_IDLE) || (level != '0);
    assign fsm_state = state;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Command storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_pulse_x, cmd_dir_x, cmd_pulse_y, cmd_dir_y, cmd_pen_down};
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level   <= level_nxt;
            cmd_rdy <= (level_nxt != FULL_LEVEL);
        end
    end

`ifdef MOTION_SEQ_AUTO_LIFT_EN
    localparam int CNT_W = $clog2(IDLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TICKS - 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             lift_cond;
    logic             lift_fire;

    assign lift_cond = (state == ST_IDLE) && (level == '0) && mot_pen_down;
    assign lift_fire = lift_cond && clk_en && (idle_cnt == CNT_LAST) && mot_rdy;

    // Count enabled ticks of an idle, empty queue with the pen still down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!lift_cond) begin
            idle_cnt <= '0;
        end else if (clk_en) begin
            if (lift_fire) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`endif

    // Issue FSM: pop into the held command registers, pulse trigger, await done.
    // A done pulse landing on a disabled tick is remembered so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mot_trigger  <= 1'b0;
            mot_pulse_x  <= '0;
            mot_dir_x    <= 1'b0;
            mot_pulse_y  <= '0;
            mot_dir_y    <= 1'b0;
            mot_pen_down <= 1'b0;
            done_pend    <= 1'b0;
        end else begin
            mot_trigger <= 1'b0;
            if (state == ST_WAIT && mot_done) begin
                done_pend <= 1'b1;
            end
            if (clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (pop) begin
                            mot_pulse_x  <= head[CW-1:PX_LO];
                            mot_dir_x    <= head[DX_B];
                            mot_pulse_y  <= head[DX_B-1:PY_LO];
                            mot_dir_y    <= head[1];
                            mot_pen_down <= head[0];
                            state        <= ST_ISSUE;
                        end
`ifdef MOTION_SEQ_AUTO_LIFT_EN
                        else if (lift_fire) begin
                            mot_pulse_x  <= '0;
                            mot_dir_x    <= 1'b0;
                            mot_pulse_y  <= '0;
                            mot_dir_y    <= 1'b0;
                            mot_pen_down <= 1'b0;
                            state        <= ST_ISSUE;
                        end
`endif
                    end
                    ST_ISSUE: begin
                        mot_trigger <= 1'b1;
                        state       <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (mot_done || done_pend) begin
                            done_pend <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Bench for motion_cmd_sequencer: randomized commands against a queue-based
// reference model of command order, with a motors-controller model.
module tb_motion_cmd_sequencer;

  localparam int PX = 16;
  localparam int PY = 16;
  localparam int DEPTH = 8;
  localparam int IDLE_TICKS = 10;
  localparam int CW = PX + PY + 3;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic cmd_valid;
  logic cmd_rdy;
  logic [PX-1:0] cmd_pulse_x;
  logic cmd_dir_x;
  logic [PY-1:0] cmd_pulse_y;
  logic cmd_dir_y;
  logic cmd_pen_down;
  logic mot_trigger;
  logic mot_rdy;
  logic mot_done;
  logic [PX-1:0] mot_pulse_x;
  logic mot_dir_x;
  logic [PY-1:0] mot_pulse_y;
  logic mot_dir_y;
  logic mot_pen_down;
  logic [$clog2(DEPTH):0] level;
  logic busy;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;
  int trig_count = 0;
  int cyc = 0;
  bit motor_hold = 0;
  bit motor_stall = 0;
  bit en_sparse = 0;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  motion_cmd_sequencer #(
    .PULSE_X_BITS(PX), .PULSE_Y_BITS(PY), .DEPTH(DEPTH), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
    .cmd_pulse_x(cmd_pulse_x), .cmd_dir_x(cmd_dir_x),
    .cmd_pulse_y(cmd_pulse_y), .cmd_dir_y(cmd_dir_y), .cmd_pen_down(cmd_pen_down),
    .mot_trigger(mot_trigger), .mot_rdy(mot_rdy), .mot_done(mot_done),
    .mot_pulse_x(mot_pulse_x), .mot_dir_x(mot_dir_x),
    .mot_pulse_y(mot_pulse_y), .mot_dir_y(mot_dir_y), .mot_pen_down(mot_pen_down),
    .level(level), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock-enable driver: every cycle, or every 4th cycle in sparse mode
  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      clk_en = en_sparse ? (cyc % 4 == 0) : 1'b1;
    end
  end

  // Motors-controller model and trigger scoreboard
  initial begin
    logic [CW-1:0] got;
    logic [CW-1:0] exp;
    bit m_busy;
    int m_cnt;
    bit prev_trig;
    bit en_prev;
    mot_rdy = 1'b1;
    mot_done = 1'b0;
    m_busy = 0;
    m_cnt = 0;
    prev_trig = 0;
    en_prev = 1;
    forever begin
      @(negedge clk);
      mot_done = 1'b0;
      if (reset) begin
        m_busy = 0;
      end else if (mot_trigger) begin
        got = {mot_pulse_x, mot_dir_x, mot_pulse_y, mot_dir_y, mot_pen_down};
        checks++;
        if (prev_trig) begin
          errors++;
          $display("FAIL trigger_width: trigger high %0d cycles in a row, required 1", 2);
        end
        checks++;
        if (!en_prev) begin
          errors++;
          $display("FAIL trigger_enable: trigger after clk_en=%0b edge, required 1", en_prev);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trigger: cmd %h issued, required no trigger", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL issue_order: got cmd %h, required %h", got, exp);
          end
        end
        trig_count++;
        m_busy = 1;
        m_cnt = $urandom_range(0, 3);
      end else if (m_busy && !motor_stall) begin
        if (m_cnt == 0) begin
          mot_done = 1'b1;
          m_busy = 0;
        end else begin
          m_cnt--;
        end
      end
      prev_trig = mot_trigger;
      en_prev = clk_en;
      mot_rdy = !m_busy && !motor_hold;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_cmd();
    logic [CW-1:0] c;
    c[31:0] = $urandom;
    c[CW-1:32] = 3'($urandom_range(0, 7));
`ifdef MOTION_SEQ_AUTO_LIFT_EN
    c[0] = 1'b0;
`endif
    return c;
  endfunction

  task automatic drive_cmd(input logic [CW-1:0] c);
    cmd_pulse_x = c[34:19];
    cmd_dir_x = c[18];
    cmd_pulse_y = c[17:2];
    cmd_dir_y = c[1];
    cmd_pen_down = c[0];
  endtask

  // Present one command; returns at posedge+1 after the accepting edge
  task automatic push_cmd(input logic [CW-1:0] c);
    int n;
    n = 0;
    while (!cmd_rdy && n < 500) begin
      tick();
      n++;
    end
    if (!cmd_rdy) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: cmd_rdy=%0b after %0d cycles, required 1", cmd_rdy, n);
    end else begin
      drive_cmd(c);
      cmd_valid = 1'b1;
      exp_q.push_back(c);
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_%s: %0d cmds pending busy=%0b, required 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b0 || mot_trigger !== 1'b0 || level !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%0b trig=%0b level=%0d busy=%0b, required 0 0 0 0",
               cmd_rdy, mot_trigger, level, busy);
    end
    checks++;
    if ({mot_pulse_x, mot_dir_x, mot_pulse_y, mot_dir_y, mot_pen_down} !== '0) begin
      errors++;
      $display("FAIL reset_mot: mot_*=%h, required 0",
               {mot_pulse_x, mot_dir_x, mot_pulse_y, mot_dir_y, mot_pen_down});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_early: cmd_rdy=%0b before first edge, required 0", cmd_rdy);
    end
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: cmd_rdy=%0b one cycle after release, required 1", cmd_rdy);
    end
    tick();
  endtask

  task automatic test_single();
    logic [CW-1:0] c;
    int n;
    c = {16'd100, 1'b1, 16'd5, 1'b0, 1'b1};
    drive_cmd(c);
    cmd_valid = 1'b1;
    exp_q.push_back(c);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 4'd1 || mot_trigger !== 1'b0) begin
      errors++;
      $display("FAIL single_n: level=%0d trig=%0b, required 1 0", level, mot_trigger);
    end
    @(negedge clk);
    checks++;
    if (mot_trigger !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n1: trig=%0b busy=%0b, required 0 1", mot_trigger, busy);
    end
    @(negedge clk);
    checks++;
    if (mot_trigger !== 1'b1 || mot_pulse_x !== 16'd100) begin
      errors++;
      $display("FAIL single_n2: trig=%0b pulse_x=%0d, required 1 100", mot_trigger, mot_pulse_x);
    end
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || mot_pen_down !== 1'b1 || mot_pulse_y !== 16'd5) begin
      errors++;
      $display("FAIL single_done: busy=%0b pen=%0b pulse_y=%0d, required 0 1 5",
               busy, mot_pen_down, mot_pulse_y);
    end
    tick();
  endtask

  task automatic test_fill();
    int base;
    motor_hold = 1;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd());
    checks++;
    if (level !== 4'd8 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: level=%0d rdy=%0b, required 8 0", level, cmd_rdy);
    end
    drive_cmd(rand_cmd());
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (level !== 4'd8) begin
        errors++;
        $display("FAIL fill_ninth: level=%0d, required 8", level);
      end
    end
    cmd_valid = 1'b0;
    base = trig_count;
    motor_hold = 0;
    wait_drain("fill");
    checks++;
    if (trig_count - base != DEPTH) begin
      errors++;
      $display("FAIL fill_count: %0d triggers, required %0d", trig_count - base, DEPTH);
    end
  endtask

  task automatic test_push_pop();
    logic [CW-1:0] c;
    motor_hold = 1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
    c = rand_cmd();
    motor_hold = 0;
    drive_cmd(c);
    cmd_valid = 1'b1;
    exp_q.push_back(c);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (level !== 4'd4) begin
      errors++;
      $display("FAIL push_pop_level: level=%0d, required 4", level);
    end
    for (int i = 0; i < 12; i++) push_cmd(rand_cmd());
    wait_drain("wrap");
  endtask

  task automatic test_clk_en();
    en_sparse = 1;
    motor_hold = 1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      push_cmd(rand_cmd());
      checks++;
      if (level !== 4'(i + 1)) begin
        errors++;
        $display("FAIL clk_en_push: level=%0d, required %0d", level, i + 1);
      end
    end
    motor_hold = 0;
    wait_drain("clk_en");
    en_sparse = 0;
    tick();
  endtask

  task automatic test_pen_idle();
    int base;
    push_cmd({16'd0, 1'b0, 16'd0, 1'b0, 1'b1});
`ifdef MOTION_SEQ_AUTO_LIFT_EN
    exp_q.push_back('0);
    wait_drain("lift");
    push_cmd({16'd7, 1'b0, 16'd3, 1'b1, 1'b1});
    wait_drain("pre_cancel");
    for (int i = 0; i < 5; i++) tick();
    push_cmd({16'd9, 1'b1, 16'd2, 1'b0, 1'b1});
    exp_q.push_back('0);
    wait_drain("cancel");
    checks++;
    if (mot_pen_down !== 1'b0) begin
      errors++;
      $display("FAIL auto_lift_pen: pen=%0b, required 0", mot_pen_down);
    end
`else
    wait_drain("pen");
    base = trig_count;
    for (int i = 0; i < 3 * IDLE_TICKS; i++) tick();
    checks++;
    if (mot_pen_down !== 1'b1 || trig_count != base) begin
      errors++;
      $display("FAIL pen_hold: pen=%0b extra_triggers=%0d, required 1 0",
               mot_pen_down, trig_count - base);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    motor_stall = 1;
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (level !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_level: level=%0d busy=%0b, required 3 1", level, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_rdy !== 1'b0 || level !== '0 || busy !== 1'b0 || mot_trigger !== 1'b0 ||
        mot_pen_down !== 1'b0 || mot_pulse_x !== '0 || mot_pulse_y !== '0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0b level=%0d busy=%0b trig=%0b pen=%0b px=%0d py=%0d, required all 0",
               cmd_rdy, level, busy, mot_trigger, mot_pen_down, mot_pulse_x, mot_pulse_y);
    end
    exp_q.delete();
    motor_stall = 0;
    tick();
    tick();
    reset = 1'b0;
    base = trig_count;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (trig_count != base || level !== '0 || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: triggers=%0d level=%0d rdy=%0b, required 0 0 1",
               trig_count - base, level, cmd_rdy);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd('0);
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_clk_en();
    test_pen_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
